// File: rtl/dynamic_output_arbiter_5.sv
// Per-output wormhole arbiter for the 5-input dynamic network crossbar: round-robin
// grant, packet-length lock, FIFO pops. Define DYNAMIC_ARB_BACK_TO_BACK_EN for tail-cycle re-arbitration.
module dynamic_output_arbiter_5 #(
    parameter int LEN_WIDTH = 8,
    parameter int NUM_IN    = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_IN-1:0]           req,
    input  logic [NUM_IN-1:0]           valid_in,
    input  logic [NUM_IN*LEN_WIDTH-1:0] len_in,
    input  logic                        out_ready,
    output logic [2:0]                  sel,
    output logic [NUM_IN-1:0]           grant,
    output logic                        out_valid,
    output logic [NUM_IN-1:0]           pop
);

    localparam logic [2:0] SEL_NONE = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [2:0]             sel_nxt;
    logic [NUM_IN-1:0]      grant_nxt;
    logic [LEN_WIDTH-1:0]   remaining, remaining_nxt;
    logic [2:0]             rr_ptr, rr_ptr_nxt;

    logic [NUM_IN-1:0]      arb_req;
    logic [3:0]             pick;
    logic                   pick_found;
    logic [2:0]             pick_idx;
    logic [LEN_WIDTH-1:0]   pick_len;
    logic                   xfer;

    // Returns {found, index}; the search begins just after the previous winner.
    function automatic logic [3:0] rr_pick(input logic [NUM_IN-1:0] r, input logic [2:0] ptr);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (!res[3] && r[idx]) res = {1'b1, 3'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        arb_req = req;
`ifdef DYNAMIC_ARB_BACK_TO_BACK_EN
        // During a tail transfer the current owner must not immediately win again.
        if (state == BUSY) arb_req = req & ~grant;
`endif
    end

    assign pick       = rr_pick(arb_req, rr_ptr);
    assign pick_found = pick[3];
    assign pick_idx   = pick[2:0];
    assign pick_len   = len_in[int'(pick_idx)*LEN_WIDTH +: LEN_WIDTH];

    // grant is one-hot with sel, so it doubles as the valid/pop mux.
    assign out_valid = (state == BUSY) && |(grant & valid_in);
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer ? grant : '0;

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first, so no path leaves one unassigned and no latch is inferred.
        state_nxt     = state;
        sel_nxt       = sel;
        grant_nxt     = grant;
        remaining_nxt = remaining;
        rr_ptr_nxt    = rr_ptr;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt     = BUSY;
                    sel_nxt       = pick_idx;
                    grant_nxt     = NUM_IN'(1) << pick_idx;
                    remaining_nxt = pick_len;
                    rr_ptr_nxt    = pick_idx;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (remaining != '0) begin
                        remaining_nxt = remaining - LEN_WIDTH'(1);
                    end else begin
                        state_nxt = IDLE;
                        sel_nxt   = SEL_NONE;
                        grant_nxt = '0;
`ifdef DYNAMIC_ARB_BACK_TO_BACK_EN
                        if (pick_found) begin
                            state_nxt     = BUSY;
                            sel_nxt       = pick_idx;
                            grant_nxt     = NUM_IN'(1) << pick_idx;
                            remaining_nxt = pick_len;
                            rr_ptr_nxt    = pick_idx;
                        end
`endif
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = SEL_NONE;
                grant_nxt = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= SEL_NONE;
            grant     <= '0;
            remaining <= '0;
            rr_ptr    <= 3'(NUM_IN - 1);
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            grant     <= grant_nxt;
            remaining <= remaining_nxt;
            rr_ptr    <= rr_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_dynamic_output_arbiter_5.sv
// Self-checking bench for dynamic_output_arbiter_5: directed scenarios plus randomized
// traffic compared against a packet-level reference model (owner, flits left, last winner).
module tb_dynamic_output_arbiter_5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  req = '0;
    logic [4:0]  valid_in = '0;
    logic [39:0] len_in = '0;
    logic        out_ready = 1'b0;
    logic [2:0]  sel;
    logic [4:0]  grant;
    logic        out_valid;
    logic [4:0]  pop;

    int passed = 0;
    int total  = 0;

    // Reference model: who owns the output, how many flits are still to go, last winner.
    int m_owner = -1;
    int m_left  = 0;
    int m_last  = 4;

    localparam logic [13:0] IDLE_OUT = {3'd7, 5'b0, 1'b0, 5'b0};

    dynamic_output_arbiter_5 #(.LEN_WIDTH(8), .NUM_IN(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .valid_in  (valid_in),
        .len_in    (len_in),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .pop       (pop)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {sel, grant, out_valid, pop};
    endfunction

    function automatic logic [13:0] model_out();
        logic [4:0] onehot;
        logic       ov;
        if (m_owner < 0) return IDLE_OUT;
        onehot = 5'(1) << m_owner;
        ov     = valid_in[m_owner];
        return {3'(m_owner), onehot, ov, (ov && out_ready) ? onehot : 5'b0};
    endfunction

    function automatic int model_pick(input logic [4:0] r);
        for (int k = 1; k <= 5; k++) begin
            if (r[(m_last + k) % 5]) return (m_last + k) % 5;
        end
        return -1;
    endfunction

    function automatic int len_of(input int i);
        return int'(len_in[i*8 +: 8]);
    endfunction

    task automatic model_step();
        int w;
        int old;
        if (reset) begin
            m_owner = -1;
            m_left  = 0;
            m_last  = 4;
        end else if (m_owner < 0) begin
            w = model_pick(req);
            if (w >= 0) begin
                m_owner = w;
                m_left  = len_of(w) + 1;
                m_last  = w;
            end
        end else if (valid_in[m_owner] && out_ready) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                old     = m_owner;
                m_owner = -1;
`ifdef DYNAMIC_ARB_BACK_TO_BACK_EN
                w = model_pick(req & ~(5'(1) << old));
                if (w >= 0) begin
                    m_owner = w;
                    m_left  = len_of(w) + 1;
                    m_last  = w;
                end
`endif
            end
        end
    endtask

    // Advance model and DUT by one edge; inputs may be changed right after return.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        valid_in  = '0;
        out_ready = 1'b0;
        len_in    = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if (obs() !== IDLE_OUT) $display("FAIL reset_values: got %h expected %h", obs(), IDLE_OUT);
        else passed++;
        total++;
        if (obs() !== model_out()) $display("FAIL reset_model: got %h expected %h", obs(), model_out());
        else passed++;
    endtask

    task automatic test_single();
        logic [7:0] pop_cycles;
        pop_cycles = '0;
        do_reset();
        valid_in  = 5'h1f;
        out_ready = 1'b1;
        req       = 5'b00100;
        len_in[2*8 +: 8] = 8'd3;
        tick();
        req = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (obs() !== model_out()) $display("FAIL single cyc%0d: got %h expected %h", c, obs(), model_out());
            else passed++;
            if (c == 0) begin
                total++;
                if (sel !== 3'd2 || grant !== 5'b00100)
                    $display("FAIL single_grant: got sel=%0d grant=%b expected sel=2 grant=00100", sel, grant);
                else passed++;
            end
            pop_cycles[c] = pop[2];
            tick();
        end
        total++;
        if (pop_cycles !== 8'b0000_1111 || sel !== 3'd7 || grant !== 5'b0)
            $display("FAIL single_pops: got pops=%b sel=%0d grant=%b expected 00001111 7 00000", pop_cycles, sel, grant);
        else passed++;
    endtask

    task automatic test_round_robin();
        int order[$];
        int starts[$];
        logic [4:0] prev;
        int exp_order[6] = '{0, 1, 2, 3, 4, 0};
`ifdef DYNAMIC_ARB_BACK_TO_BACK_EN
        int gap = 1;
`else
        int gap = 2;
`endif
        do_reset();
        req       = 5'h1f;
        valid_in  = 5'h1f;
        out_ready = 1'b1;
        prev      = '0;
        for (int c = 0; c < 40 && order.size() < 6; c++) begin
            @(negedge clk);
            total++;
            if (obs() !== model_out()) $display("FAIL rr cyc%0d: got %h expected %h", c, obs(), model_out());
            else passed++;
            if (grant != 5'b0 && grant != prev) begin
                for (int i = 0; i < 5; i++) if (grant[i]) order.push_back(i);
                starts.push_back(c);
            end
            prev = grant;
            tick();
        end
        total++;
        if (order.size() != 6) $display("FAIL rr_timeout: got %0d grants expected 6", order.size());
        else passed++;
        for (int i = 0; i < order.size() && i < 6; i++) begin
            total++;
            if (order[i] != exp_order[i]) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
            else passed++;
            if (i > 0) begin
                total++;
                if (starts[i] - starts[i-1] != gap)
                    $display("FAIL rr_gap[%0d]: got %0d expected %0d", i, starts[i] - starts[i-1], gap);
                else passed++;
            end
        end
    endtask

    task automatic test_stalls();
        int pops = 0;
        int held_bad = 0;
        do_reset();
        valid_in = 5'h1f;
        req      = 5'b00010;
        len_in[1*8 +: 8] = 8'd2;
        tick();
        req = '0;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 3);
            valid_in  = (c == 3 || c == 4) ? 5'b11101 : 5'h1f;
            req       = 5'($urandom);
            @(negedge clk);
            total++;
            if (obs() !== model_out()) $display("FAIL stall cyc%0d: got %h expected %h", c, obs(), model_out());
            else passed++;
            if (pops < 3 && grant !== 5'b00010) held_bad++;
            if (pop[1]) pops++;
            tick();
        end
        total++;
        if (pops != 3 || held_bad != 0)
            $display("FAIL stall_lock: got pops=%0d lost_grant=%0d expected 3 0", pops, held_bad);
        else passed++;
    endtask

    task automatic test_max_len();
        int pops = 0;
        bit released = 0;
        do_reset();
        valid_in  = 5'h1f;
        out_ready = 1'b1;
        req       = 5'b10000;
        len_in[4*8 +: 8] = 8'hff;
        tick();
        req = '0;
        for (int c = 0; c < 300 && !released; c++) begin
            @(negedge clk);
            total++;
            if (obs() !== model_out()) $display("FAIL maxlen cyc%0d: got %h expected %h", c, obs(), model_out());
            else passed++;
            if (pop[4]) pops++;
            if (grant == 5'b0) released = 1;
            tick();
        end
        total++;
        if (!released || pops != 256)
            $display("FAIL maxlen_pops: got pops=%0d released=%0d expected 256 1", pops, released);
        else passed++;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        valid_in  = 5'h1f;
        out_ready = 1'b1;
        req       = 5'b01000;
        len_in[3*8 +: 8] = 8'd4;
        tick();
        req = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (obs() !== model_out()) $display("FAIL midrst cyc%0d: got %h expected %h", c, obs(), model_out());
            else passed++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (obs() !== IDLE_OUT) $display("FAIL midrst_idle: got %h expected %h", obs(), IDLE_OUT);
        else passed++;
        req    = 5'h1f;
        len_in = '0;
        tick();
        @(negedge clk);
        total++;
        if (grant !== 5'b00001 || obs() !== model_out())
            $display("FAIL midrst_rearb: got %h expected %h", obs(), model_out());
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] seen[5];
`ifdef DYNAMIC_ARB_BACK_TO_BACK_EN
        logic [4:0] exp_pop[5] = '{5'b00001, 5'b00001, 5'b00010, 5'b00010, 5'b00001};
`else
        logic [4:0] exp_pop[5] = '{5'b00001, 5'b00001, 5'b00000, 5'b00010, 5'b00010};
`endif
        do_reset();
        valid_in  = 5'h1f;
        out_ready = 1'b1;
        req       = 5'b00011;
        len_in[0 +: 8] = 8'd1;
        len_in[8 +: 8] = 8'd1;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen[c] = pop;
            total++;
            if (obs() !== model_out()) $display("FAIL b2b cyc%0d: got %h expected %h", c, obs(), model_out());
            else passed++;
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (seen[c] !== exp_pop[c]) $display("FAIL b2b_pop[%0d]: got %b expected %b", c, seen[c], exp_pop[c]);
            else passed++;
        end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(299) == 0);
            req       = 5'($urandom);
            out_ready = ($urandom_range(3) != 0);
            for (int i = 0; i < 5; i++) begin
                valid_in[i]      = ($urandom_range(4) != 0);
                len_in[i*8 +: 8] = ($urandom_range(9) == 0) ? 8'($urandom) : 8'($urandom_range(3));
            end
            @(negedge clk);
            total++;
            if (obs() !== model_out()) begin
                errs++;
                if (errs <= 20) $display("FAIL random cyc%0d: got %h expected %h", c, obs(), model_out());
            end else passed++;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stalls();
        test_max_len();
        test_reset_mid_packet();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
